// File: rtl/local_mac_package.sv
// rtl/local_mac_package.sv - MAC datapath sizing shared across the MAC slice
package local_mac_package;

    localparam int MAC_CNT_LEN = 4096;

endpackage

// File: rtl/mac_ctrl_package.sv
// rtl/mac_ctrl_package.sv - job sequencer types and sizing
package mac_ctrl_package;

    import local_mac_package::MAC_CNT_LEN;

    localparam int MAC_LEN_W    = $clog2(MAC_CNT_LEN);
    localparam int MAC_NB_OUT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } mac_ctrl_state_t;

    // Descriptor as presented by a job source.
    typedef struct packed {
        logic                    simple_mul;
        logic [4:0]              shift;
        logic [MAC_LEN_W-1:0]    len;
        logic [MAC_NB_OUT_W-1:0] nb_out;
    } mac_job_t;

endpackage

// File: rtl/mac_ctrl_counter.sv
// rtl/mac_ctrl_counter.sv - up counter with sync clear and terminal-count compare
module mac_ctrl_counter #(
    parameter int W = 8
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         at_term
);

    // Count accepted events; clear wins over enable.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign at_term = (cnt == term);

endmodule

// File: rtl/mac_job_ctrl.sv
// rtl/mac_job_ctrl.sv - job sequencer gating a/b operand streams and counting d results
module mac_job_ctrl
    import mac_ctrl_package::*;
#(
    parameter int  MAC_CNT_LEN = local_mac_package::MAC_CNT_LEN,
    parameter int  NB_OUT_W    = 16,
    localparam int LEN_W       = $clog2(MAC_CNT_LEN)
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                clear,

    input  logic                job_valid,
    output logic                job_ready,
    input  logic                job_simple_mul,
    input  logic [4:0]          job_shift,
    input  logic [LEN_W-1:0]    job_len,
    input  logic [NB_OUT_W-1:0] job_nb_out,

    input  logic                a_in_valid,
    output logic                a_in_ready,
    input  logic [31:0]         a_in_data,
    input  logic                b_in_valid,
    output logic                b_in_ready,
    input  logic [31:0]         b_in_data,

    output logic                a_out_valid,
    input  logic                a_out_ready,
    output logic [31:0]         a_out_data,
    output logic                b_out_valid,
    input  logic                b_out_ready,
    output logic [31:0]         b_out_data,

    input  logic                d_in_valid,
    output logic                d_in_ready,
    input  logic [31:0]         d_in_data,
    output logic                d_out_valid,
    input  logic                d_out_ready,
    output logic [31:0]         d_out_data,

    output logic                reg_simple_mul,
    output logic [4:0]          reg_shift,
    output logic [LEN_W-1:0]    reg_len,

    output logic                busy,
    output logic                done
);

    // Wide enough for nb_out * MAC_CNT_LEN without overflow.
    localparam int TP_W = NB_OUT_W + LEN_W + 1;

    mac_ctrl_state_t     state_q;
    mac_ctrl_state_t     state_d;

    logic [TP_W-1:0]     tot_pairs_q;
    logic [NB_OUT_W-1:0] nb_out_q;

    logic [TP_W-1:0]     pair_cnt;
    logic [NB_OUT_W-1:0] out_cnt;
    logic                pair_last;
    logic                out_last;

    logic                job_acc;
    logic                fwd_ab;
    logic                fwd_d;
    logic                pair_hs;
    logic                d_hs;
    logic                cnt_clr;

    // Operand gate is open only while pairs are still owed; result path stays
    // open until the last result is delivered.
    assign fwd_ab  = (state_q == RUN);
    assign fwd_d   = (state_q == RUN) || (state_q == DRAIN);

    assign job_acc = job_valid & job_ready & ~clear;

    assign a_out_valid = fwd_ab & a_in_valid;
    assign b_out_valid = fwd_ab & b_in_valid;
    assign a_in_ready  = fwd_ab & a_out_ready;
    assign b_in_ready  = fwd_ab & b_out_ready;
    assign a_out_data  = a_in_data;
    assign b_out_data  = b_in_data;

    // Outside a job the d stream is drained into the floor so a MAC left with
    // partial work after an abort empties itself.
    assign d_out_valid = fwd_d & d_in_valid;
    assign d_in_ready  = fwd_d ? d_out_ready : 1'b1;
    assign d_out_data  = d_in_data;

    assign pair_hs = fwd_ab & a_in_valid & a_out_ready & b_in_valid & b_out_ready;
    assign d_hs    = fwd_d & d_in_valid & d_out_ready;

    // Counters sit at zero whenever no job is in flight.
    assign cnt_clr = clear | ~fwd_d;

    mac_ctrl_counter #(
        .W (TP_W)
    ) u_pair_cnt (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clear    (cnt_clr),
        .en       (pair_hs),
        .term     (tot_pairs_q - TP_W'(1)),
        .cnt      (pair_cnt),
        .at_term  (pair_last)
    );

    mac_ctrl_counter #(
        .W (NB_OUT_W)
    ) u_out_cnt (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clear    (cnt_clr),
        .en       (d_hs),
        .term     (nb_out_q - NB_OUT_W'(1)),
        .cnt      (out_cnt),
        .at_term  (out_last)
    );

    // Latch the descriptor and its pair budget on accept; held after the job ends.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            reg_simple_mul <= 1'b0;
            reg_shift      <= '0;
            reg_len        <= '0;
            nb_out_q       <= '0;
            tot_pairs_q    <= '0;
        end else if (job_acc) begin
            reg_simple_mul <= job_simple_mul;
            reg_shift      <= job_shift;
            reg_len        <= job_len;
            nb_out_q       <= job_nb_out;
            tot_pairs_q    <= job_simple_mul
                            ? TP_W'(job_nb_out)
                            : TP_W'(job_nb_out) * TP_W'({1'b0, job_len} + (LEN_W+1)'(1));
        end
    end

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and status outputs; a final result ends the job even if
    // operand pairs are still being counted.
    always_comb begin
        state_d   = state_q;
        job_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) begin
                    state_d = (job_nb_out == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (d_hs && out_last) begin
                    state_d = DONE;
                end else if (pair_hs && pair_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (d_hs && out_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_mac_job_ctrl.sv
// tb/tb_mac_job_ctrl.sv - self-checking bench for mac_job_ctrl
module tb_mac_job_ctrl;

    localparam int LEN_W    = 12;
    localparam int NB_OUT_W = 16;

    logic                ap_clk;
    logic                ap_rst_n;
    logic                clear;
    logic                job_valid;
    logic                job_ready;
    logic                job_simple_mul;
    logic [4:0]          job_shift;
    logic [LEN_W-1:0]    job_len;
    logic [NB_OUT_W-1:0] job_nb_out;
    logic                a_in_valid, a_in_ready;
    logic [31:0]         a_in_data;
    logic                b_in_valid, b_in_ready;
    logic [31:0]         b_in_data;
    logic                a_out_valid, a_out_ready;
    logic [31:0]         a_out_data;
    logic                b_out_valid, b_out_ready;
    logic [31:0]         b_out_data;
    logic                d_in_valid, d_in_ready;
    logic [31:0]         d_in_data;
    logic                d_out_valid, d_out_ready;
    logic [31:0]         d_out_data;
    logic                reg_simple_mul;
    logic [4:0]          reg_shift;
    logic [LEN_W-1:0]    reg_len;
    logic                busy;
    logic                done;

    mac_job_ctrl dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .clear          (clear),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_simple_mul (job_simple_mul),
        .job_shift      (job_shift),
        .job_len        (job_len),
        .job_nb_out     (job_nb_out),
        .a_in_valid     (a_in_valid),
        .a_in_ready     (a_in_ready),
        .a_in_data      (a_in_data),
        .b_in_valid     (b_in_valid),
        .b_in_ready     (b_in_ready),
        .b_in_data      (b_in_data),
        .a_out_valid    (a_out_valid),
        .a_out_ready    (a_out_ready),
        .a_out_data     (a_out_data),
        .b_out_valid    (b_out_valid),
        .b_out_ready    (b_out_ready),
        .b_out_data     (b_out_data),
        .d_in_valid     (d_in_valid),
        .d_in_ready     (d_in_ready),
        .d_in_data      (d_in_data),
        .d_out_valid    (d_out_valid),
        .d_out_ready    (d_out_ready),
        .d_out_data     (d_out_data),
        .reg_simple_mul (reg_simple_mul),
        .reg_shift      (reg_shift),
        .reg_len        (reg_len),
        .busy           (busy),
        .done           (done)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    typedef struct {
        bit                  sm;
        logic [4:0]          sh;
        logic [LEN_W-1:0]    ln;
        logic [NB_OUT_W-1:0] nb;
        bit                  bp;
        int                  extra;
        int                  exp_pairs;
    } job_vec_t;

    job_vec_t    vecs[6];
    logic [31:0] exp_q[$];
    logic [31:0] mac_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] a_val(input int i);
        return 64'(i + 1);
    endfunction

    function automatic logic [63:0] b_val(input int i);
        return 64'(i + 5);
    endfunction

    task automatic idle_inputs();
        job_valid   = 1'b0;
        clear       = 1'b0;
        a_in_valid  = 1'b0;
        b_in_valid  = 1'b0;
        d_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        d_out_ready = 1'b1;
    endtask

    task automatic accept(input bit sm, input logic [4:0] sh, input logic [LEN_W-1:0] ln,
                          input logic [NB_OUT_W-1:0] nb);
        @(negedge ap_clk);
        job_simple_mul = sm;
        job_shift      = sh;
        job_len        = ln;
        job_nb_out     = nb;
        job_valid      = 1'b1;
        #1;
        check("job_ready_idle", job_ready, 1);
    endtask

    task automatic run_job(input int id, input job_vec_t v);
        int          g, n_supply, pair_idx, fwd, rcv, cyc, done_cyc, last_d_cyc, done_cnt, mcnt;
        logic [63:0] acc, macc;
        bit          src_v, hs;
        exp_q.delete();
        mac_q.delete();
        g        = v.sm ? 1 : int'(v.ln) + 1;
        n_supply = v.exp_pairs + v.extra;
        for (int r = 0; r < int'(v.nb); r++) begin
            acc = '0;
            for (int k = 0; k < g; k++) acc += a_val(r*g + k) * b_val(r*g + k);
            exp_q.push_back(32'(acc >> v.sh));
        end
        accept(v.sm, v.sh, v.ln, v.nb);
        cyc = 0; done_cyc = -1; last_d_cyc = 0; pair_idx = 0; fwd = 0; rcv = 0;
        done_cnt = 0; src_v = 1'b0; macc = '0; mcnt = 0;
        while (cyc < 3000) begin
            @(negedge ap_clk);
            cyc++;
            job_valid = 1'b0;
            if (!src_v && pair_idx < n_supply)
                src_v = v.bp ? ($urandom_range(0, 99) >= 30) : 1'b1;
            a_in_valid  = src_v;
            b_in_valid  = src_v;
            a_in_data   = 32'(a_val(pair_idx));
            b_in_data   = 32'(b_val(pair_idx));
            a_out_ready = v.bp ? ($urandom_range(0, 99) >= 30) : 1'b1;
            b_out_ready = a_out_ready;
            d_in_valid  = (mac_q.size() > 0);
            d_in_data   = d_in_valid ? mac_q[0] : 32'hdead_beef;
            d_out_ready = v.bp ? ($urandom_range(0, 99) >= 30) : 1'b1;
            #1;
            if (cyc == 1) begin
                check($sformatf("j%0d_busy_n1", id), busy, 1);
                check($sformatf("j%0d_job_ready_n1", id), job_ready, 0);
                check($sformatf("j%0d_reg_simple_mul", id), reg_simple_mul, v.sm);
                check($sformatf("j%0d_reg_shift", id), reg_shift, v.sh);
            end
            if (busy) check($sformatf("j%0d_reg_len_stable", id), reg_len, v.ln);
            hs = a_out_valid & a_out_ready & b_out_valid & b_out_ready;
            if (hs) begin
                check($sformatf("j%0d_a_data", id), a_out_data, 32'(a_val(pair_idx)));
                check($sformatf("j%0d_b_data", id), b_out_data, 32'(b_val(pair_idx)));
                fwd++;
                macc += a_out_data * b_out_data;
                mcnt++;
                if (mcnt == g) begin
                    mac_q.push_back(32'(macc >> v.sh));
                    macc = '0;
                    mcnt = 0;
                end
            end
            if (a_in_valid && a_in_ready) begin
                pair_idx++;
                src_v = 1'b0;
            end
            if (d_out_valid && d_out_ready) begin
                rcv++;
                last_d_cyc = cyc;
                if (exp_q.size() == 0) check($sformatf("j%0d_d_extra", id), rcv, v.nb);
                else check($sformatf("j%0d_d_data", id), d_out_data, exp_q.pop_front());
            end
            if (d_in_valid && d_in_ready) void'(mac_q.pop_front());
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check($sformatf("j%0d_job_ready_after", id), job_ready, 1);
                check($sformatf("j%0d_busy_after", id), busy, 0);
                break;
            end
        end
        check($sformatf("j%0d_finished", id), done_cyc >= 0, 1);
        check($sformatf("j%0d_pairs", id), fwd, v.exp_pairs);
        check($sformatf("j%0d_results", id), rcv, v.nb);
        check($sformatf("j%0d_done_count", id), done_cnt, 1);
        check($sformatf("j%0d_done_cycle", id), done_cyc, (v.nb == 0) ? 1 : last_d_cyc + 1);
        idle_inputs();
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd0, 12'd0,  16'd4, 1'b0, 2, 4};
        vecs[1] = '{1'b0, 5'd0, 12'd3,  16'd2, 1'b0, 4, 8};
        vecs[2] = '{1'b0, 5'd2, 12'd15, 16'd3, 1'b1, 3, 48};
        vecs[3] = '{1'b1, 5'd0, 12'd5,  16'd0, 1'b0, 3, 0};
        vecs[4] = '{1'b1, 5'd1, 12'd7,  16'd1, 1'b1, 1, 1};
        vecs[5] = '{1'b0, 5'd4, 12'd0,  16'd5, 1'b1, 2, 5};

        ap_rst_n       = 1'b0;
        job_simple_mul = 1'b0;
        job_shift      = '0;
        job_len        = '0;
        job_nb_out     = '0;
        a_in_data      = '0;
        b_in_data      = '0;
        d_in_data      = '0;
        idle_inputs();
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Reset state, with upstream traffic offered to prove gates are shut.
        @(negedge ap_clk);
        a_in_valid = 1'b1;
        b_in_valid = 1'b1;
        d_in_valid = 1'b1;
        #1;
        check("rst_job_ready", job_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_a_in_ready", a_in_ready, 0);
        check("rst_b_in_ready", b_in_ready, 0);
        check("rst_d_out_valid", d_out_valid, 0);
        check("rst_d_in_ready", d_in_ready, 1);
        check("rst_regs", {reg_simple_mul, reg_shift, reg_len}, 0);
        idle_inputs();

        for (int i = 0; i < 6; i++) run_job(i, vecs[i]);

        // Abort mid-RUN after 5 of 8 pairs.
        accept(1'b0, 5'd2, 12'd3, 16'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge ap_clk);
            job_valid  = 1'b0;
            a_in_valid = 1'b1;
            b_in_valid = 1'b1;
            a_in_data  = 32'(a_val(k));
            b_in_data  = 32'(b_val(k));
            #1;
            check("clr_pair_hs", a_out_valid & b_out_valid, 1);
        end
        @(negedge ap_clk);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        clear      = 1'b1;
        #1;
        check("clr_busy_before", busy, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge ap_clk);
            clear      = 1'b0;
            a_in_valid = 1'b1;
            b_in_valid = 1'b1;
            d_in_valid = 1'b1;
            d_in_data  = 32'h0000_1234;
            #1;
            check("clr_busy", busy, 0);
            check("clr_job_ready", job_ready, 1);
            check("clr_no_done", done, 0);
            check("clr_a_gate", {a_out_valid, a_in_ready}, 0);
            check("clr_d_out_valid", d_out_valid, 0);
            check("clr_d_in_ready", d_in_ready, 1);
            check("clr_reg_shift_kept", reg_shift, 2);
        end
        // Clear beats a simultaneous job accept.
        @(negedge ap_clk);
        idle_inputs();
        job_simple_mul = 1'b1;
        job_shift      = 5'd31;
        job_nb_out     = 16'd3;
        job_valid      = 1'b1;
        clear          = 1'b1;
        @(negedge ap_clk);
        job_valid = 1'b0;
        clear     = 1'b0;
        #1;
        check("clr_prio_busy", busy, 0);
        check("clr_prio_reg_shift", reg_shift, 2);
        check("clr_prio_reg_mul", reg_simple_mul, 0);
        run_job(6, vecs[1]);

        // Async reset while waiting for results in DRAIN.
        accept(1'b1, 5'd3, 12'd9, 16'd2);
        for (int k = 0; k < 2; k++) begin
            @(negedge ap_clk);
            job_valid  = 1'b0;
            a_in_valid = 1'b1;
            b_in_valid = 1'b1;
            a_in_data  = 32'(a_val(k));
            b_in_data  = 32'(b_val(k));
        end
        @(negedge ap_clk);
        #1;
        check("drain_busy", busy, 1);
        check("drain_a_gate", {a_out_valid, a_in_ready}, 0);
        check("drain_reg_len", reg_len, 9);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_job_ready", job_ready, 1);
        check("arst_done", done, 0);
        check("arst_regs", {reg_simple_mul, reg_shift, reg_len}, 0);
        check("arst_d_in_ready", d_in_ready, 1);
        check("arst_a_out_valid", a_out_valid, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        idle_inputs();
        run_job(7, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_job_ctrl.md
# mac_job_ctrl

Job sequencer for the `mul_mdc` MAC datapath. It accepts one job descriptor at a time (mode, shift, vector length, number of results) and drives the MAC configuration inputs, holding them stable for the whole job. It gates the a/b operand streams so that exactly the required number of operand pairs enters the MAC, then counts results on the d stream and signals completion. It sits between the streamer/source side and `mul_mdc`, with the d stream passing through it to the sink.

## Interface
- `MAC_CNT_LEN`, 4096: maximum vector length; `LEN_W = $clog2(MAC_CNT_LEN)`.
- `NB_OUT_W`, 16: width of the results-per-job field.
- `ap_clk` in 1: clock.
- `ap_rst_n` in 1: reset, asynchronous, active-low.
- `clear` in 1: synchronous abort; returns to IDLE.
- `job_valid` / `job_ready` in / out 1: descriptor handshake.
- `job_simple_mul` in 1: 1 selects simple multiply, 0 selects scalar product.
- `job_shift` in 5: shift amount.
- `job_len` in LEN_W: scalar-product vector length minus one.
- `job_nb_out` in NB_OUT_W: number of d results in the job.
- `a_in_valid` / `a_in_ready` / `a_in_data` in / out / in 1/1/32: source a stream.
- `b_in_*`: same as `a_in_*`, for source b.
- `a_out_valid` / `a_out_ready` / `a_out_data` out / in / out 1/1/32: to MAC a stream.
- `b_out_*`: same as `a_out_*`, to MAC b stream.
- `d_in_valid` / `d_in_ready` / `d_in_data` in / out / in 1/1/32: from MAC d stream.
- `d_out_valid` / `d_out_ready` / `d_out_data` out / in / out 1/1/32: to sink.
- `reg_simple_mul` out 1, `reg_shift` out 5, `reg_len` out LEN_W: MAC configuration.
- `busy` out 1: high when state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `job_ready` = 1.
  - On `job_valid & job_ready`: latch the descriptor into the `reg_*` outputs and `nb_out_q`.
  - Compute `tot_pairs` = `job_simple_mul ? job_nb_out : job_nb_out*(job_len+1)`, registered, width NB_OUT_W+LEN_W+1.
  - Next state is RUN; if `job_nb_out == 0`, next state is DONE.
- RUN:
  - a/b are forwarded combinationally: `x_out_valid = x_in_valid`, `x_in_ready = x_out_ready`, data passes through.
  - A pair is counted when both a_out and b_out handshake in the same cycle; `pair_cnt` increments.
  - The last pair (`pair_cnt == tot_pairs-1` with a pair handshake) moves the FSM to DRAIN.
- DRAIN, and IDLE/DONE:
  - `a_out_valid`, `b_out_valid`, `a_in_ready`, `b_in_ready` are all 0.
- RUN and DRAIN, d path:
  - d is forwarded combinationally; `out_cnt` increments on each `d_out` handshake.
  - The last result (`out_cnt == nb_out_q-1` with a handshake) moves the FSM to DONE, from either RUN or DRAIN.
  - If the last result is handshaken in RUN, the FSM goes directly to DONE.
- DONE: `done` = 1 for one cycle, then IDLE. Counters are zeroed on entry to IDLE.
- IDLE/DONE, d path: `d_out_valid` = 0 and `d_in_ready` = 1. Stray MAC results are discarded, which flushes the MAC after an abort.
- `reg_*` outputs change only on a job accept and persist after the job ends.
- `clear` (any state):
  - Next cycle the FSM is IDLE with counters at 0.
  - `done` is not pulsed; `reg_*` keep their values.
  - `clear` has priority over a simultaneous job accept, and the job is not latched.
- Arithmetic is unsigned. Counters never wrap within a legal job; `tot_pairs` is sized to the maximum product.

## Timing
- Reset values:
  - `job_ready` = 1.
  - `busy`, `done`, `a/b_out_valid`, `a/b_in_ready`, `d_out_valid` = 0.
  - `d_in_ready` = 1.
  - `reg_simple_mul`, `reg_shift`, `reg_len` = 0.
  - state = IDLE, all counters 0.
- A job accepted at edge N: `busy` = 1 and a/b forwarding is enabled from cycle N+1; `reg_*` are valid at N+1.
- Zero added latency on all stream paths; all paths are purely combinational valid/ready passthrough.
- Last d handshake at edge M: `done` = 1 in cycle M+1, `job_ready` = 1 in cycle M+2.
- `nb_out` = 0: `done` in cycle N+1, with no stream activity.
- `job_ready` is 0 whenever `busy` is high; there is a single outstanding job.
- Stream rules: valid never depends on ready within this block. Data and valid are held stable by the upstream source; the block does not alter them mid-handshake except at gate closure. Gates close only on state change, which follows a completed handshake.

## Structure
- Package `mac_ctrl_package`:
  - imports `MAC_CNT_LEN` from `local_mac_package`.
  - `typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mac_ctrl_state_t`.
  - packed struct `mac_job_t` with fields {simple_mul, shift, len, nb_out}.
- Sub-module `mac_ctrl_counter`: parameterised width; clear, enable, terminal-count compare. It is instantiated twice, for pairs and for outputs.

## Test plan
- Simple mode: `nb_out`=4, shift=0, a={1,2,3,4}, b={5,6,7,8} → exactly 4 pairs forwarded, d={5,12,21,32} passed through, `done` one cycle after the 4th d handshake.
- Scalar mode: len=3, `nb_out`=2, 8 pairs supplied plus 4 extra → `a_in_ready`=0 after the 8th pair; 2 d results; `done` pulses once; `reg_len`=3 is stable for the whole job.
- Backpressure: random `d_out_ready` and a/b valids with 30% idle, len=15, `nb_out`=3 → 48 pairs, 3 results, no loss, stable data under stall.
- `nb_out`=0 → `done` at N+1, no a/b forwarding.
- `clear` mid-RUN after 5 of 8 pairs → IDLE next cycle, no `done`, stray `d_in` absorbed with `d_out_valid`=0; the next job runs correctly.
- Async reset asserted mid-DRAIN → all outputs at reset values immediately; a job accepted after reset completes.
